// File: rtl/mult128_pkg.sv
// Shared constants for the 128-bit multiplier sequencer: FSM encodings,
// control bit positions, status field layout and result geometry.
package mult128_pkg;

    localparam int NUM_LIMBS = 4;
    localparam int NPAIRS    = 16;
    localparam int LIMB_W    = 32;
    localparam int RES_W     = 256;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CTRL_LOAD  = 0;
    localparam int CTRL_START = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int SR_STATE_LSB = 0;
    localparam int SR_DONE      = 2;
    localparam int SR_BUSY      = 3;
    localparam int SR_ERR       = 4;
    localparam int SR_CNT_LSB   = 5;

    // Limb-pair index k = 4i + j maps to a left shift of (i + j) limbs.
    function automatic logic [2:0] pair_shift(input logic [3:0] k);
        return {1'b0, k[3:2]} + {1'b0, k[1:0]};
    endfunction

endpackage

// File: rtl/mult128_seq_ctrl_if.sv
// GPIO-side and multiplier-side signal bundle of the 128-bit multiplier sequencer.
interface mult128_seq_ctrl_if;

    logic [31:0] in_loc;
    logic [31:0] in_val;
    logic [31:0] ctrl_reg;
    logic [31:0] rd_loc;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic [31:0] out_loc;
    logic [31:0] out_val;
    logic [31:0] state_reg;

    modport master (
        output in_loc, in_val, ctrl_reg, rd_loc, mul_p,
        input  mul_a, mul_b, out_loc, out_val, state_reg
    );

    modport slave (
        input  in_loc, in_val, ctrl_reg, rd_loc, mul_p,
        output mul_a, mul_b, out_loc, out_val, state_reg
    );

endinterface

// File: rtl/mult128_acc.sv
// 256-bit accumulator: adds a 64-bit partial product shifted by a whole
// number of 32-bit limbs, with full carry propagation in a single cycle.
module mult128_acc
    import mult128_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             vld,
    input  logic [2:0]       shift,
    input  logic [63:0]      prod,
    output logic [RES_W-1:0] acc
);

    logic [RES_W-1:0] addend;

    assign addend = {{(RES_W - 64){1'b0}}, prod} << {shift, 5'd0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (vld) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/mult128_seq_ctrl.sv
// Sequencer for the 128x128 multiplier: captures operand limbs from GPIO,
// issues 16 limb pairs to an external pipelined 32x32 multiplier, accumulates.
module mult128_seq_ctrl
    import mult128_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int LIMBS   = NUM_LIMBS
) (
    input  logic              clk,
    input  logic              reset,
    mult128_seq_ctrl_if.slave bus
);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic               err;
    logic [2:0]         ctrl_prev;
    logic [31:0]        a_q [LIMBS];
    logic [31:0]        b_q [LIMBS];
    logic [31:0]        mul_a_q;
    logic [31:0]        mul_b_q;
    logic [31:0]        out_val_q;
    logic [31:0]        out_loc_q;
    logic [MUL_LAT-1:0] vld_p;
    logic [2:0]         sh_p [MUL_LAT];
    logic [RES_W-1:0]   acc;
    logic [31:0]        sr;

    logic load_e;
    logic start_e;
    logic clr_e;
    logic busy;
    logic issue_now;
    logic upstream_vld;
    logic acc_clr;
    logic unused_ctrl;

    assign load_e    = bus.ctrl_reg[CTRL_LOAD]  & ~ctrl_prev[CTRL_LOAD];
    assign start_e   = bus.ctrl_reg[CTRL_START] & ~ctrl_prev[CTRL_START];
    assign clr_e     = bus.ctrl_reg[CTRL_CLEAR] & ~ctrl_prev[CTRL_CLEAR];
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign issue_now = (state == ST_ISSUE) && !clr_e;
    assign acc_clr   = clr_e || (start_e && !busy);
    assign unused_ctrl = ^bus.ctrl_reg[31:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            ctrl_prev <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            for (int l = 0; l < LIMBS; l++) begin
                a_q[l] <= '0;
                b_q[l] <= '0;
            end
        end else begin
            ctrl_prev <= bus.ctrl_reg[2:0];
            if (clr_e) begin
                state <= ST_IDLE;
                cnt   <= '0;
                err   <= 1'b0;
                for (int l = 0; l < LIMBS; l++) begin
                    a_q[l] <= '0;
                    b_q[l] <= '0;
                end
            end else begin
                // The load is applied before the start so a same-cycle limb is used.
                if (load_e) begin
                    if (busy || bus.in_loc > 32'd7) begin
                        err <= 1'b1;
                    end else if (bus.in_loc[2]) begin
                        b_q[bus.in_loc[1:0]] <= bus.in_val;
                    end else begin
                        a_q[bus.in_loc[1:0]] <= bus.in_val;
                    end
                end
                if (start_e) begin
                    if (busy) begin
                        err <= 1'b1;
                    end else begin
                        state <= ST_ISSUE;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                if (state == ST_ISSUE) begin
                    mul_a_q <= a_q[cnt[3:2]];
                    mul_b_q <= b_q[cnt[1:0]];
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'(NPAIRS - 1)) begin
                        state <= ST_DRAIN;
                    end
                end else if (state == ST_DRAIN && !upstream_vld) begin
                    state <= ST_DONE;
                end
            end
        end
    end

    // Stage p0..p(MUL_LAT-1): valid/shift tag tracks each product through the multiplier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                sh_p[s] <= '0;
            end
        end else begin
            vld_p[0] <= issue_now;
            sh_p[0]  <= pair_shift(cnt);
            for (int s = 1; s < MUL_LAT; s++) begin
                vld_p[s] <= vld_p[s-1] & ~clr_e;
                sh_p[s]  <= sh_p[s-1];
            end
        end
    end

    // Last accumulate happens when only the final stage still holds a product.
    always_comb begin
        upstream_vld = 1'b0;
        for (int s = 0; s < MUL_LAT - 1; s++) begin
            upstream_vld = upstream_vld | vld_p[s];
        end
    end

    mult128_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .vld   (vld_p[MUL_LAT-1] & ~clr_e),
        .shift (sh_p[MUL_LAT-1]),
        .prod  (bus.mul_p),
        .acc   (acc)
    );

    // Readback stage: one-cycle registered limb select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q <= '0;
            out_loc_q <= '0;
        end else begin
            out_val_q <= acc[{bus.rd_loc[2:0], 5'd0} +: 32];
            out_loc_q <= bus.rd_loc;
        end
    end

    always_comb begin
        sr                      = '0;
        sr[SR_STATE_LSB +: 2]   = state;
        sr[SR_DONE]             = (state == ST_DONE);
        sr[SR_BUSY]             = busy;
        sr[SR_ERR]              = err;
        sr[SR_CNT_LSB +: 4]     = cnt;
    end

    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_loc   = out_loc_q;
    assign bus.state_reg = sr;

endmodule

// File: tb/tb_mult128_seq_ctrl.sv
// Bench for mult128_seq_ctrl: directed vectors, an external multiplier stand-in,
// and a time-based reference model compared every cycle.
module tb_mult128_seq_ctrl;

    localparam int MUL_LAT  = 3;
    localparam int DONE_LAT = 17 + MUL_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    mult128_seq_ctrl_if ifc ();

    mult128_seq_ctrl #(.MUL_LAT(MUL_LAT), .LIMBS(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Product appears MUL_LAT cycles after the issue cycle (operands arrive one cycle later).
    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign ifc.mul_p = {32'd0, ifc.mul_a} * {32'd0, ifc.mul_b};
        end else begin : g_mul_pipe
            logic [63:0] dly [MUL_LAT-1];
            always @(posedge clk) begin
                dly[0] <= {32'd0, ifc.mul_a} * {32'd0, ifc.mul_b};
                for (int s = 1; s < MUL_LAT - 1; s++) dly[s] <= dly[s-1];
            end
            assign ifc.mul_p = dly[MUL_LAT-2];
        end
    endgenerate

    logic [31:0]  m_a [4];
    logic [31:0]  m_b [4];
    logic [31:0]  m_ca [4];
    logic [31:0]  m_cb [4];
    logic         m_err = 1'b0;
    logic         m_run = 1'b0;
    logic [2:0]   m_prev = 3'd0;
    logic [255:0] m_res = '0;
    int           cyc = 0;
    int           m_t0 = 0;
    logic         exp_rd_ok = 1'b0;
    logic [31:0]  exp_val = '0;
    logic [31:0]  exp_loc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model with the inputs
    // the next rising edge will sample, then return just after that edge.
    task automatic tick();
        int          d;
        int          idx;
        logic [31:0] sr_exp;
        logic        le, se, ce, busy_now;
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_state_reg", 64'(ifc.state_reg), 64'd0);
            chk("reset_out_val", 64'(ifc.out_val), 64'd0);
            chk("reset_out_loc", 64'(ifc.out_loc), 64'd0);
            chk("reset_mul_a", 64'(ifc.mul_a), 64'd0);
            chk("reset_mul_b", 64'(ifc.mul_b), 64'd0);
            for (int i = 0; i < 4; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            m_err = 1'b0; m_run = 1'b0; m_res = '0; m_prev = 3'd0;
            exp_rd_ok = 1'b1; exp_val = '0; exp_loc = '0;
        end else begin
            d = cyc - m_t0;
            sr_exp = '0;
            sr_exp[4] = m_err;
            if (m_run) begin
                if (d < 16) begin
                    sr_exp[1:0] = 2'd1; sr_exp[3] = 1'b1; sr_exp[8:5] = d[3:0];
                end else if (d < DONE_LAT - 1) begin
                    sr_exp[1:0] = 2'd2; sr_exp[3] = 1'b1;
                end else begin
                    sr_exp[1:0] = 2'd3; sr_exp[2] = 1'b1;
                end
            end
            chk("state_reg", 64'(ifc.state_reg), 64'(sr_exp));
            if (exp_rd_ok) begin
                chk("out_val", 64'(ifc.out_val), 64'(exp_val));
                chk("out_loc", 64'(ifc.out_loc), 64'(exp_loc));
            end
            if (m_run && d >= 1) begin
                idx = (d > 16) ? 15 : d - 1;
                chk("mul_a", 64'(ifc.mul_a), 64'(m_ca[idx / 4]));
                chk("mul_b", 64'(ifc.mul_b), 64'(m_cb[idx % 4]));
            end
            busy_now  = m_run && (d < DONE_LAT - 1);
            exp_rd_ok = !busy_now;
            exp_val   = m_run ? m_res[ifc.rd_loc[2:0] * 32 +: 32] : 32'd0;
            exp_loc   = ifc.rd_loc;
            le = ifc.ctrl_reg[0] & ~m_prev[0];
            se = ifc.ctrl_reg[1] & ~m_prev[1];
            ce = ifc.ctrl_reg[2] & ~m_prev[2];
            m_prev = ifc.ctrl_reg[2:0];
            if (ce) begin
                for (int i = 0; i < 4; i++) begin
                    m_a[i] = '0;
                    m_b[i] = '0;
                end
                m_err = 1'b0; m_run = 1'b0; m_res = '0;
            end else begin
                if (le) begin
                    if (busy_now || ifc.in_loc > 32'd7) m_err = 1'b1;
                    else if (ifc.in_loc < 32'd4) m_a[ifc.in_loc[1:0]] = ifc.in_val;
                    else m_b[ifc.in_loc[1:0]] = ifc.in_val;
                end
                if (se) begin
                    if (busy_now) begin
                        m_err = 1'b1;
                    end else begin
                        m_err = 1'b0;
                        m_run = 1'b1;
                        m_t0  = cyc + 1;
                        m_ca  = m_a;
                        m_cb  = m_b;
                        m_res = {128'd0, m_a[3], m_a[2], m_a[1], m_a[0]} *
                                {128'd0, m_b[3], m_b[2], m_b[1], m_b[0]};
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] loc, input logic [31:0] val);
        ifc.in_loc = loc; ifc.in_val = val; ifc.ctrl_reg = 32'd1;
        tick();
        ifc.ctrl_reg = 32'd0;
        tick();
    endtask

    task automatic read_limb(input int idx, input logic [31:0] exp, input string nm);
        ifc.rd_loc = 32'(idx);
        tick();
        chk($sformatf("%s[%0d]", nm, idx), 64'(ifc.out_val), 64'(exp));
    endtask

    // Start, optionally disturb (start at s_at, load at l_at), wait for done.
    task automatic run(input logic [31:0] first, input int s_at, input int l_at, output int lat);
        ifc.ctrl_reg = first;
        tick();
        lat = 1;
        while (!ifc.state_reg[2] && lat < 200) begin
            if (lat == s_at) begin
                ifc.ctrl_reg = 32'd2;
            end else if (lat == l_at) begin
                ifc.in_loc = 32'd0; ifc.in_val = 32'h1234_5678; ifc.ctrl_reg = 32'd1;
            end else begin
                ifc.ctrl_reg = 32'd0;
            end
            tick();
            lat++;
        end
        ifc.ctrl_reg = 32'd0;
    endtask

    task automatic check_max(input string nm);
        read_limb(0, 32'h0000_0001, nm);
        for (int i = 1; i < 4; i++) read_limb(i, 32'h0, nm);
        read_limb(4, 32'hFFFF_FFFE, nm);
        for (int i = 5; i < 8; i++) read_limb(i, 32'hFFFF_FFFF, nm);
    endtask

    initial begin
        int lat;
        ifc.in_loc = '0; ifc.in_val = '0; ifc.ctrl_reg = '0; ifc.rd_loc = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) read_limb(i, 32'h0, "init_limb");
        chk("idle_state_reg", 64'(ifc.state_reg), 64'd0);

        // 3 * 5
        load(32'd0, 32'd3);
        load(32'd4, 32'd5);
        run(32'd2, 0, 0, lat);
        chk("small_done_lat", 64'(lat), 64'(DONE_LAT));
        chk("small_state", 64'(ifc.state_reg), 64'h0000_000F & 64'h7);
        read_limb(0, 32'h0000_000F, "small_limb");
        for (int i = 1; i < 8; i++) read_limb(i, 32'h0, "small_limb");

        // Reset in the middle of an operation
        ifc.ctrl_reg = 32'd2;
        tick();
        ifc.ctrl_reg = 32'd0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) read_limb(i, 32'h0, "post_reset_limb");
        chk("post_reset_state", 64'(ifc.state_reg), 64'd0);

        // (2^128-1)^2
        for (int i = 0; i < 8; i++) load(32'(i), 32'hFFFF_FFFF);
        run(32'd2, 0, 0, lat);
        chk("max_done_lat", 64'(lat), 64'(DONE_LAT));
        chk("max_err", 64'(ifc.state_reg[4]), 64'd0);
        check_max("max_limb");

        // Start at k=5 and load at k=8 while busy
        run(32'd2, 6, 9, lat);
        chk("busy_done_lat", 64'(lat), 64'(DONE_LAT));
        chk("busy_err", 64'(ifc.state_reg[4]), 64'd1);
        check_max("busy_limb");
        run(32'd2, 0, 0, lat);
        chk("rerun_done_lat", 64'(lat), 64'(DONE_LAT));
        chk("rerun_err", 64'(ifc.state_reg[4]), 64'd0);
        check_max("rerun_limb");

        // Clear during DRAIN with products in flight
        ifc.ctrl_reg = 32'd2;
        tick();
        ifc.ctrl_reg = 32'd0;
        repeat (16) tick();
        chk("drain_state", 64'(ifc.state_reg[1:0]), 64'd2);
        ifc.ctrl_reg = 32'd4;
        tick();
        ifc.ctrl_reg = 32'd0;
        chk("clear_state_reg", 64'(ifc.state_reg), 64'd0);
        for (int i = 0; i < 20; i++) read_limb(i % 8, 32'h0, "clear_limb");

        // Bad location, then load and start together
        load(32'd0, 32'd2);
        load(32'd8, 32'd99);
        chk("bad_loc_err", 64'(ifc.state_reg[4]), 64'd1);
        ifc.in_loc = 32'd4; ifc.in_val = 32'd7;
        run(32'd3, 0, 0, lat);
        chk("ldst_done_lat", 64'(lat), 64'(DONE_LAT));
        chk("ldst_err", 64'(ifc.state_reg[4]), 64'd0);
        read_limb(0, 32'd14, "ldst_limb");
        for (int i = 1; i < 8; i++) read_limb(i, 32'h0, "ldst_limb");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
